// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Brief   : Alternating-priority arbiter of I-side and D-side cache line
//           requests onto one shared main-memory port, with sticky timeout.
// Revision: 1.0
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W  = 14,
  parameter int LINE_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_rdy,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_rdy,
  output logic [LINE_W-1:0] d_rdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_rdy,
  output logic              err
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_owner;      // 1 = D side owns the transaction
  logic              r_last;       // 1 = D side was granted last
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic [LINE_W-1:0] r_i_rdata;
  logic [LINE_W-1:0] r_d_rdata;
  logic [TMR_W-1:0]  r_timer;
  logic              r_err;
  logic              r_post_resp;
  logic              w_i_pend;
  logic              w_d_pend;
  logic              w_grant;
  logic              w_grant_d;
  logic              w_timeout;

  // The side served last may still show req for one cycle after its rdy pulse.
  always_comb begin
    w_i_pend  = i_req & ~(r_post_resp & ~r_owner);
    w_d_pend  = d_req & ~(r_post_resp & r_owner);
    w_grant   = w_i_pend | w_d_pend;
    w_grant_d = w_d_pend & (~w_i_pend | ~r_last);
    w_timeout = (r_timer == TMR_W'(TIMEOUT));
    w_next    = r_state;
    case (r_state)
      S_IDLE:  if (w_grant) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (mem_rdy || w_timeout) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner     <= 1'b0;
      r_last      <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
      r_timer     <= '0;
      r_err       <= 1'b0;
      r_post_resp <= 1'b0;
    end else begin
      r_post_resp <= (r_state == S_RESP);
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_owner <= w_grant_d;
            r_last  <= w_grant_d;
            r_we    <= w_grant_d & d_we;
            r_addr  <= w_grant_d ? d_addr : i_addr;
            r_wdata <= w_grant_d ? d_wdata : '0;
          end
        end
        S_WAIT: begin
          if (mem_rdy || w_timeout) begin
            r_timer <= '0;
            if (!mem_rdy) r_err <= 1'b1;
            // A timed-out read returns an all-zero line.
            if (!r_we) begin
              if (r_owner) r_d_rdata <= mem_rdy ? mem_rdata : '0;
              else         r_i_rdata <= mem_rdy ? mem_rdata : '0;
            end
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_re    = (r_state == S_ISSUE) & ~r_we;
  assign mem_we    = (r_state == S_ISSUE) & r_we;
  assign mem_addr  = (r_state == S_ISSUE || r_state == S_WAIT) ? r_addr : '0;
  assign mem_wdata = ((r_state == S_ISSUE || r_state == S_WAIT) && r_we) ? r_wdata : '0;
  assign i_rdy     = (r_state == S_RESP) & ~r_owner;
  assign d_rdy     = (r_state == S_RESP) & r_owner;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Brief   : Directed self-checking bench for mem_arbiter.
// Revision: 1.0
// ============================================================================
module tb_mem_arbiter;

  localparam int ADDR_W  = 14;
  localparam int LINE_W  = 64;
  localparam int TIMEOUT = 255;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_req, d_req, d_we, mem_rdy;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic [LINE_W-1:0] d_wdata, mem_rdata;
  logic              i_rdy, d_rdy, mem_re, mem_we, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] i_rdata, d_rdata, mem_wdata;

  int   tests   = 0;
  int   fails   = 0;
  int   strobes = 0;
  int   s0;
  logic exp_d;

  localparam logic [63:0] LINE_A = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] LINE_B = 64'hFEDC_BA98_7654_3210;

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdy(i_rdy), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdy(d_rdy), .d_rdata(d_rdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rdy(mem_rdy), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rst_n && (mem_re || mem_we)) strobes <= strobes + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200us");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // I-side read at 0x0010, memory answers 3 cycles after the strobe;
  // the requester drops i_req one cycle late.
  task automatic case1(input string t);
    i_req = 1'b1; i_addr = 14'h0010;
    @(negedge clk);
    chk({t, "_strobe"}, {63'd0, mem_re}, 64'd1);
    chk({t, "_no_we"}, {63'd0, mem_we}, 64'd0);
    chk({t, "_addr"}, {50'd0, mem_addr}, 64'h10);
    @(negedge clk);
    chk({t, "_strobe_1cyc"}, {63'd0, mem_re}, 64'd0);
    chk({t, "_addr_held"}, {50'd0, mem_addr}, 64'h10);
    @(negedge clk);
    @(negedge clk);
    chk({t, "_no_early_rdy"}, {63'd0, i_rdy}, 64'd0);
    mem_rdy = 1'b1; mem_rdata = 64'h1111_2222_3333_4444;
    @(negedge clk);
    mem_rdy = 1'b0; mem_rdata = '0;
    chk({t, "_i_rdy"}, {63'd0, i_rdy}, 64'd1);
    chk({t, "_i_rdata"}, i_rdata, 64'h1111_2222_3333_4444);
    chk({t, "_d_rdy"}, {63'd0, d_rdy}, 64'd0);
    @(negedge clk);
    chk({t, "_i_rdy_pulse"}, {63'd0, i_rdy}, 64'd0);
    chk({t, "_i_rdata_hold"}, i_rdata, 64'h1111_2222_3333_4444);
    @(negedge clk);
    chk({t, "_masked_no_reissue"}, {63'd0, mem_re}, 64'd0);
    i_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_rdy = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ctrl", {59'd0, i_rdy, d_rdy, mem_re, mem_we, err}, 64'd0);
    chk("rst_mem_addr", {50'd0, mem_addr}, 64'd0);
    chk("rst_rdata", i_rdata | d_rdata | mem_wdata, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single I-side read
    case1("t1");

    // 2: simultaneous requests after reset -> D first, then I
    do_reset();
    s0 = strobes;
    i_req = 1'b1; i_addr = 14'h0040;
    d_req = 1'b1; d_we = 1'b0; d_addr = 14'h0080;
    @(negedge clk);
    chk("t2_d_strobe", {63'd0, mem_re}, 64'd1);
    chk("t2_d_addr", {50'd0, mem_addr}, 64'h80);
    @(negedge clk);
    mem_rdy = 1'b1; mem_rdata = LINE_A;
    @(negedge clk);
    mem_rdy = 1'b0;
    chk("t2_d_rdy", {62'd0, d_rdy, i_rdy}, 64'b10);
    chk("t2_d_rdata", d_rdata, LINE_A);
    d_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t2_i_strobe", {63'd0, mem_re}, 64'd1);
    chk("t2_i_addr", {50'd0, mem_addr}, 64'h40);
    @(negedge clk);
    mem_rdy = 1'b1; mem_rdata = LINE_B;
    @(negedge clk);
    mem_rdy = 1'b0;
    chk("t2_i_rdy", {62'd0, d_rdy, i_rdy}, 64'b01);
    chk("t2_i_rdata", i_rdata, LINE_B);
    chk("t2_d_rdata_hold", d_rdata, LINE_A);
    i_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t2_strobe_count", 64'(strobes - s0), 64'd2);

    // 3: D-side line write
    d_req = 1'b1; d_we = 1'b1; d_addr = 14'h02A0; d_wdata = 64'hDEAD_BEEF_CAFE_F00D;
    @(negedge clk);
    chk("t3_we", {62'd0, mem_we, mem_re}, 64'b10);
    chk("t3_addr", {50'd0, mem_addr}, 64'h2A0);
    chk("t3_wdata", mem_wdata, 64'hDEAD_BEEF_CAFE_F00D);
    @(negedge clk);
    chk("t3_we_1cyc", {63'd0, mem_we}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    chk("t3_addr_held", {50'd0, mem_addr}, 64'h2A0);
    chk("t3_wdata_held", mem_wdata, 64'hDEAD_BEEF_CAFE_F00D);
    mem_rdy = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    mem_rdy = 1'b0; mem_rdata = '0;
    chk("t3_d_rdy", {63'd0, d_rdy}, 64'd1);
    chk("t3_d_rdata_unchanged", d_rdata, LINE_A);
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    chk("t3_d_rdy_pulse", {63'd0, d_rdy}, 64'd0);

    // 4: both requests held -> D,I,D,I,D,I
    do_reset();
    s0 = strobes;
    i_req = 1'b1; i_addr = 14'h0100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 14'h0200;
    for (int k = 0; k < 6; k++) begin
      exp_d = (k % 2 == 0);
      @(negedge clk);
      chk("t4_strobe", {63'd0, mem_re}, 64'd1);
      chk("t4_addr", {50'd0, mem_addr}, exp_d ? 64'h200 : 64'h100);
      @(negedge clk);
      mem_rdy = 1'b1; mem_rdata = 64'hA5A5_0000_0000_0000 | 64'(k);
      @(negedge clk);
      mem_rdy = 1'b0;
      chk("t4_owner", {62'd0, d_rdy, i_rdy}, exp_d ? 64'b10 : 64'b01);
      chk("t4_data", exp_d ? d_rdata : i_rdata, 64'hA5A5_0000_0000_0000 | 64'(k));
      if (k == 5) begin
        i_req = 1'b0; d_req = 1'b0;
      end
      @(negedge clk);
      chk("t4_idle", {63'd0, mem_re}, 64'd0);
    end
    @(negedge clk);
    chk("t4_strobe_count", 64'(strobes - s0), 64'd6);

    // 5: memory never answers -> timeout
    i_req = 1'b1; i_addr = 14'h0003;
    @(negedge clk);
    chk("t5_strobe", {63'd0, mem_re}, 64'd1);
    repeat (TIMEOUT + 1) @(negedge clk);
    chk("t5_last_wait", {62'd0, err, i_rdy}, 64'd0);
    chk("t5_addr_held", {50'd0, mem_addr}, 64'h3);
    @(negedge clk);
    chk("t5_err", {63'd0, err}, 64'd1);
    chk("t5_i_rdy", {63'd0, i_rdy}, 64'd1);
    chk("t5_zero_data", i_rdata, 64'd0);
    i_req = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_err_sticky", {62'd0, err, i_rdy}, 64'b10);

    // 6: reset during WAIT, late mem_rdy ignored
    i_req = 1'b1; i_addr = 14'h0010;
    @(negedge clk);
    @(negedge clk);
    chk("t6_in_wait", {50'd0, mem_addr}, 64'h10);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ctrl", {59'd0, i_rdy, d_rdy, mem_re, mem_we, err}, 64'd0);
    chk("t6_rst_addr", {50'd0, mem_addr}, 64'd0);
    chk("t6_rst_rdata", i_rdata | d_rdata, 64'd0);
    i_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; mem_rdy = 1'b1; mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    @(negedge clk);
    mem_rdy = 1'b0; mem_rdata = '0;
    chk("t6_late_rdy_ignored", {61'd0, i_rdy, d_rdy, mem_re}, 64'd0);
    chk("t6_rdata_clear", i_rdata, 64'd0);
    @(negedge clk);
    case1("t6c1");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
